chroma_luma_fwd_xform: RTL
==========================

CHROMA_LUMA_FWD_XFORM -- requirements
Module: chroma_luma_fwd_xform

Interface
REQ-001 SHALL have parameter WORD_LEN, default 16, meaning the signed output coefficient width.
REQ-002 SHALL have parameter BIT_LEN, default 17, meaning the internal intermediate width of the row pass.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port s_data, input, 128, the input block. Pel block: 16 unsigned 8-bit pels, lane i = bits 8i+7:8i, 4x4 row-major. DC block: four zero-extended 12-bit sums in 16-bit lanes 0..3 (bits 63:0), upper bits ignored.
REQ-006 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_last (input, 1), where s_last marks the final transfer of a macroblock.
REQ-007 SHALL have port m_data, output, 16*WORD_LEN (256), sixteen signed coefficients, lane i = bits 16i+15:16i, row-major.
REQ-008 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_last (output, 1).
REQ-009 SHALL have port m_kind, output, 2, meaning 0 luma, 1 chroma AC, 2 chroma DC.
REQ-010 SHALL have port m_idx, output, 5, the block index 0..25 within the macroblock.
REQ-011 SHALL have port sync_err, output, 1, a sticky flag set on an s_last/index mismatch.

Function
REQ-012 SHALL accept 26 transfers per macroblock in this index order: 0-15 luma, 16 CbDC, 17-20 Cb AC, 21 CrDC, 22-25 Cr AC.
REQ-013 SHALL keep a 5-bit index counter that advances on each s_valid&&s_ready and wraps from 25 to 0.
REQ-014 SHALL, on an accepted s_last, treat that transfer as index 25 and restart at 0; if the counter was not 25, it SHALL set sync_err.
REQ-015 SHALL, for an accepted transfer at index 25 without s_last, set sync_err; m_last is still driven from the counter.
REQ-016 SHALL compute Y = Cf*X*Cf^T on pel blocks, with Cf rows [1,1,1,1], [2,1,-1,-2], [1,-1,-1,1], [1,-2,2,-1].
REQ-017 SHALL, on DC blocks, compute the 2x2 Hadamard of c0..c3 (lanes 0..3): lane0 = c0+c1+c2+c3, lane1 = c0-c1+c2-c3, lane2 = c0+c1-c2-c3, lane3 = c0-c1-c2+c3, with lanes 4-15 set to 0.
REQ-018 SHALL use a row pass of BIT_LEN signed bits and a column pass producing WORD_LEN signed results; no saturation is applied, because the maximum magnitude 9180 (pel) and 16320 (DC) fits.
REQ-019 SHALL be a 3-stage elastic pipeline (row, column, output register); the minimum latency from input acceptance to m_valid is 3 cycles.
REQ-020 SHALL sustain throughput of 1 transfer per cycle when m_ready is held high.
REQ-021 SHALL implement per-stage ready as ready[k] = !valid[k] || ready[k+1], with the final stage ready = !m_valid || m_ready.
REQ-022 SHALL hold m_data, m_last, m_kind and m_idx stable while m_valid && !m_ready.
REQ-023 SHALL assert m_last only with idx 25.
REQ-024 SHALL carry kind, idx and last alongside the data through every stage.
REQ-025 SHALL complete a simultaneous input accept and output drain at a stage in the same cycle without bubble or loss.
REQ-026 SHALL never drop or duplicate a transfer under any m_ready pattern.

Reset
REQ-027 SHALL, while reset is asserted, hold all stage valids at 0, s_ready at 0, m_valid at 0, m_last at 0, m_kind at 0, m_idx at 0, the counter at 0 and sync_err at 0.
REQ-028 SHALL drive s_ready to 1 in the first cycle after reset is released.
REQ-029 SHALL discard all in-flight data on reset mid-operation, with the counter restarting at index 0.
REQ-030 SHALL NOT require reset values for the data registers.

Structure
REQ-031 SHALL take the kind encoding enum, the index constants 16/21/25 and the Cf coefficient constants from a shared package, gg264_xform_pkg.
REQ-032 SHALL instantiate one sub-module, xform_1d4, a combinational 4-point forward butterfly used 4x in the row pass and 4x in the column pass.
REQ-033 SHALL implement the DC Hadamard as a mux path inside the same stages.

Verification
REQ-034 SHALL verify: all pels = 10 at idx 0 -> lane0 = 160, other lanes 0, kind 0, 3-cycle latency.
REQ-035 SHALL verify: pel[0] = 1, others 0 -> lanes 0..7 = 1,2,1,1,2,4,2,2; lanes 8..15 = 1,2,1,1,1,2,1,1.
REQ-036 SHALL verify: DC block at idx 16 with c = 100,20,30,10 -> lanes 0..3 = 160,100,80,60, lanes 4-15 = 0, kind 2.
REQ-037 SHALL verify: 3 macroblocks back-to-back with random m_ready (30% low) -> 78 outputs in order, m_last on every 26th, data stable while stalled.
REQ-038 SHALL verify: s_last on the 20th transfer -> sync_err = 1, the next transfer has idx 0, and the following 26 transfers produce the correct m_last.
REQ-039 SHALL verify: reset asserted with 3 blocks in flight -> m_valid = 0 immediately, and after release the first output has idx 0.

Source files
------------

// File: rtl/gg264_xform_pkg.sv
// Shared definitions for the 4x4 forward transform: block kinds,
// macroblock index landmarks and the forward core transform matrix.
`timescale 1ns/1ps
package gg264_xform_pkg;

  typedef enum logic [1:0] {
    KIND_LUMA      = 2'd0,
    KIND_CHROMA_AC = 2'd1,
    KIND_CHROMA_DC = 2'd2
  } blk_kind_e;

  // Positions within the 26-transfer macroblock sequence.
  localparam logic [4:0] IDX_CB_DC = 5'd16;
  localparam logic [4:0] IDX_CR_DC = 5'd21;
  localparam logic [4:0] IDX_LAST  = 5'd25;

  // Forward core transform matrix Cf (row-major).
  localparam int CF [4][4] = '{
    '{1,  1,  1,  1},
    '{2,  1, -1, -2},
    '{1, -1, -1,  1},
    '{1, -2,  2, -1}
  };

  // Block kind implied by a position in the macroblock sequence.
  function automatic blk_kind_e kind_of(input logic [4:0] idx);
    if (idx < IDX_CB_DC) begin
      return KIND_LUMA;
    end
    if (idx == IDX_CB_DC || idx == IDX_CR_DC) begin
      return KIND_CHROMA_DC;
    end
    return KIND_CHROMA_AC;
  endfunction

endpackage

// File: rtl/xform_1d4.sv
// Combinational 4-point forward butterfly: y[k] = sum_j Cf[k][j] * x[j].
// Lanes are packed little-endian, IN_W / OUT_W bits each, all signed.
`timescale 1ns/1ps
module xform_1d4
  import gg264_xform_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int OUT_W = 17
) (
  input  logic [4*IN_W-1:0]  x,
  output logic [4*OUT_W-1:0] y
);

  localparam int AW = (IN_W > OUT_W) ? IN_W : OUT_W;

  // Coefficients are constants in {+-1,+-2}, so this folds into shifts and adds.
  always_comb begin
    logic signed [AW-1:0] acc;
    y = '0;
    for (int k = 0; k < 4; k++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        acc = acc + AW'(CF[k][j]) * AW'($signed(x[j*IN_W +: IN_W]));
      end
      y[k*OUT_W +: OUT_W] = acc[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/chroma_luma_fwd_xform.sv
// Forward 4x4 integer transform for luma/chroma AC blocks and 2x2 Hadamard
// for chroma DC blocks, as a 3-stage elastic pipeline (row, column, output).
// Block kind, index and last travel with the data through every stage.
`timescale 1ns/1ps
module chroma_luma_fwd_xform
  import gg264_xform_pkg::*;
#(
  parameter int WORD_LEN = 16,
  parameter int BIT_LEN  = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [127:0]            s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  output logic [16*WORD_LEN-1:0]  m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [1:0]              m_kind,
  output logic [4:0]              m_idx,
  output logic                    sync_err
);

  genvar gi, gj;

  // Handshake and sequencing state.
  logic            rdy1, rdy2, rdy3, accept;
  logic [4:0]      idx_reg, idx_next, eff_idx;
  logic            sync_err_reg, sync_err_next;
  blk_kind_e       in_kind;
  logic            in_dc;

  // Stage 1: row pass.
  logic                     s1_valid_reg, s1_dc_reg, s1_last_reg;
  blk_kind_e                s1_kind_reg;
  logic [4:0]               s1_idx_reg;
  logic [16*BIT_LEN-1:0]    s1_data_reg;

  // Stage 2: column pass.
  logic                     s2_valid_reg, s2_last_reg;
  blk_kind_e                s2_kind_reg;
  logic [4:0]               s2_idx_reg;
  logic [16*WORD_LEN-1:0]   s2_data_reg;

  // Stage 3: output register.
  logic                     s3_valid_reg, m_last_reg;
  blk_kind_e                m_kind_reg;
  logic [4:0]               m_idx_reg;
  logic [16*WORD_LEN-1:0]   m_data_reg;

  // Datapath nets.
  logic [16*BIT_LEN-1:0]    row_bf, dc_row, row_next;
  logic [16*WORD_LEN-1:0]   col_bf, dc_col, col_next;
  logic signed [BIT_LEN-1:0]  dc_c [4];
  logic signed [WORD_LEN-1:0] dc_r [4];

  // A stage can take new data when empty or when its successor is taking its data.
  assign rdy3    = !s3_valid_reg || m_ready;
  assign rdy2    = !s2_valid_reg || rdy3;
  assign rdy1    = !s1_valid_reg || rdy2;
  assign s_ready = !reset && rdy1;
  assign accept  = s_valid && s_ready;

  // s_last forces the transfer to the final slot, whatever the counter says.
  assign eff_idx = s_last ? IDX_LAST : idx_reg;
  assign in_kind = kind_of(eff_idx);
  assign in_dc   = (in_kind == KIND_CHROMA_DC);

  // Macroblock position counter and sticky framing error.
  always_comb begin
    idx_next      = idx_reg;
    sync_err_next = sync_err_reg;
    if (accept) begin
      idx_next = (s_last || idx_reg == IDX_LAST) ? 5'd0 : idx_reg + 5'd1;
      if (s_last != (idx_reg == IDX_LAST)) begin
        sync_err_next = 1'b1;
      end
    end
  end

  // Row pass: each pel row goes through one butterfly.
  for (gi = 0; gi < 4; gi++) begin : g_row
    logic [4*BIT_LEN-1:0] row_x;
    for (gj = 0; gj < 4; gj++) begin : g_pel
      assign row_x[gj*BIT_LEN +: BIT_LEN] = {{(BIT_LEN-8){1'b0}}, s_data[8*(4*gi+gj) +: 8]};
    end
    xform_1d4 #(.IN_W(BIT_LEN), .OUT_W(BIT_LEN)) u_row (
      .x (row_x),
      .y (row_bf[4*gi*BIT_LEN +: 4*BIT_LEN])
    );
  end

  // DC sums sit in 16-bit lanes 0..3; they are non-negative so zero-extend.
  for (gi = 0; gi < 4; gi++) begin : g_dc_in
    assign dc_c[gi] = {{(BIT_LEN-16){1'b0}}, s_data[16*gi +: 16]};
  end

  // First half of the 2x2 Hadamard: pairwise sum/difference of c0,c1 and c2,c3.
  always_comb begin
    dc_row                          = '0;
    dc_row[0*BIT_LEN +: BIT_LEN]    = dc_c[0] + dc_c[1];
    dc_row[1*BIT_LEN +: BIT_LEN]    = dc_c[0] - dc_c[1];
    dc_row[2*BIT_LEN +: BIT_LEN]    = dc_c[2] + dc_c[3];
    dc_row[3*BIT_LEN +: BIT_LEN]    = dc_c[2] - dc_c[3];
    row_next = in_dc ? dc_row : row_bf;
  end

  // Column pass: each column of the row-pass result goes through one butterfly.
  for (gi = 0; gi < 4; gi++) begin : g_col
    logic [4*BIT_LEN-1:0]  col_x;
    logic [4*WORD_LEN-1:0] col_y;
    for (gj = 0; gj < 4; gj++) begin : g_lane
      assign col_x[gj*BIT_LEN +: BIT_LEN] = s1_data_reg[(4*gj+gi)*BIT_LEN +: BIT_LEN];
      assign col_bf[(4*gj+gi)*WORD_LEN +: WORD_LEN] = col_y[gj*WORD_LEN +: WORD_LEN];
    end
    xform_1d4 #(.IN_W(BIT_LEN), .OUT_W(WORD_LEN)) u_col (
      .x (col_x),
      .y (col_y)
    );
  end

  // Row-stage DC partials narrowed to output width; magnitudes always fit.
  for (gi = 0; gi < 4; gi++) begin : g_dc_mid
    assign dc_r[gi] = WORD_LEN'($signed(s1_data_reg[gi*BIT_LEN +: BIT_LEN]));
  end

  // Second half of the 2x2 Hadamard; lanes 4..15 stay zero.
  always_comb begin
    dc_col                           = '0;
    dc_col[0*WORD_LEN +: WORD_LEN]   = dc_r[0] + dc_r[2];
    dc_col[1*WORD_LEN +: WORD_LEN]   = dc_r[1] + dc_r[3];
    dc_col[2*WORD_LEN +: WORD_LEN]   = dc_r[0] - dc_r[2];
    dc_col[3*WORD_LEN +: WORD_LEN]   = dc_r[1] - dc_r[3];
    col_next = s1_dc_reg ? dc_col : col_bf;
  end

  // Control state: valids, counter, error flag and output sideband.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg      <= 5'd0;
      sync_err_reg <= 1'b0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      m_last_reg   <= 1'b0;
      m_kind_reg   <= KIND_LUMA;
      m_idx_reg    <= 5'd0;
    end else begin
      idx_reg      <= idx_next;
      sync_err_reg <= sync_err_next;
      if (rdy1) begin
        s1_valid_reg <= accept;
      end
      if (rdy2) begin
        s2_valid_reg <= s1_valid_reg;
      end
      if (rdy3) begin
        s3_valid_reg <= s2_valid_reg;
        if (s2_valid_reg) begin
          m_last_reg <= s2_last_reg;
          m_kind_reg <= s2_kind_reg;
          m_idx_reg  <= s2_idx_reg;
        end
      end
    end
  end

  // Payload registers load only when their stage takes a valid item.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data_reg <= row_next;
      s1_dc_reg   <= in_dc;
      s1_kind_reg <= in_kind;
      s1_idx_reg  <= eff_idx;
      s1_last_reg <= (eff_idx == IDX_LAST);
    end
    if (rdy2 && s1_valid_reg) begin
      s2_data_reg <= col_next;
      s2_kind_reg <= s1_kind_reg;
      s2_idx_reg  <= s1_idx_reg;
      s2_last_reg <= s1_last_reg;
    end
    if (rdy3 && s2_valid_reg) begin
      m_data_reg <= s2_data_reg;
    end
  end

  assign m_valid  = s3_valid_reg;
  assign m_data   = m_data_reg;
  assign m_last   = m_last_reg;
  assign m_kind   = m_kind_reg;
  assign m_idx    = m_idx_reg;
  assign sync_err = sync_err_reg;

endmodule
